// File: rtl/sio32_slave.sv
`default_nettype none
// ============================================================================
//  Module   : sio32_slave
//  Purpose  : EPL-side serial I/O expander of the SIO32 link. The serial
//             clock, data and frame-enable pins are oversampled in the local
//             system clock domain. Each frame shifts 32 output bits into
//             port_out and shifts a snapshot of port_in back out on epl_sdo.
//             epl_int flags any change of port_in since the last snapshot.
//  Ports    : csi_MCLK_clk    - system clock (>= 8x EPL_SCLK)
//             rsi_MRST_reset  - asynchronous active-high reset
//             epl_sclk/sdi/sle- serial clock, data in, frame enable (async)
//             epl_sdo         - serial data out, updated on SCLK fall
//             epl_int         - level interrupt, port_in changed
//             port_in[31:0]   - parallel inputs reported to the master
//             port_out[31:0]  - parallel outputs received from the master
//             frame_done      - one-cycle pulse when port_out commits
//             frame_err       - sticky short-frame flag
//  Options  : SIO32_SLAVE_GLITCH_FILTER_EN - 3-sample majority filter on the
//             synchronised sclk/sle (adds 2 cycles of latency)
//  Revision : 1.0 - initial release
// ============================================================================
module sio32_slave #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] OUT_RESET   = 32'h0000_0000,
    parameter int          MIN_BITS    = 32
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic        epl_sclk,
    input  logic        epl_sdi,
    input  logic        epl_sle,
    output logic        epl_sdo,
    output logic        epl_int,
    input  logic [31:0] port_in,
    output logic [31:0] port_out,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [6:0] C_MIN_BITS = 7'(MIN_BITS);
    localparam logic [6:0] C_CNT_MAX  = 7'd127;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic [SYNC_STAGES-1:0] sle_sync_q;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            sle_sync_q  <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], epl_sclk};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0],  epl_sdi};
            sle_sync_q  <= {sle_sync_q[SYNC_STAGES-2:0],  epl_sle};
        end
    end

    logic w_sclk_s;
    logic w_sdi_s;
    logic w_sle_s;
    assign w_sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign w_sdi_s  = sdi_sync_q[SYNC_STAGES-1];
    assign w_sle_s  = sle_sync_q[SYNC_STAGES-1];

    // Level seen by the edge detectors
    logic w_sclk_v;
    logic w_sle_v;

`ifdef SIO32_SLAVE_GLITCH_FILTER_EN
    // Majority of the current and two previous samples, registered.
    // sdi is not filtered: it is stable for many cycles around each
    // sclk fall, so the extra 2 cycles on sclk do not disturb sampling.
    logic [1:0] sclk_hist_q;
    logic [1:0] sle_hist_q;
    logic       sclk_filt_q;
    logic       sle_filt_q;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            sclk_hist_q <= '0;
            sle_hist_q  <= '0;
            sclk_filt_q <= 1'b0;
            sle_filt_q  <= 1'b0;
        end else begin
            sclk_hist_q <= {sclk_hist_q[0], w_sclk_s};
            sle_hist_q  <= {sle_hist_q[0],  w_sle_s};
            sclk_filt_q <= (w_sclk_s & sclk_hist_q[0]) | (w_sclk_s & sclk_hist_q[1])
                         | (sclk_hist_q[0] & sclk_hist_q[1]);
            sle_filt_q  <= (w_sle_s & sle_hist_q[0]) | (w_sle_s & sle_hist_q[1])
                         | (sle_hist_q[0] & sle_hist_q[1]);
        end
    end

    assign w_sclk_v = sclk_filt_q;
    assign w_sle_v  = sle_filt_q;
`else
    assign w_sclk_v = w_sclk_s;
    assign w_sle_v  = w_sle_s;
`endif

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic sclk_prev_q;
    logic sle_prev_q;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            sclk_prev_q <= 1'b0;
            sle_prev_q  <= 1'b0;
        end else begin
            sclk_prev_q <= w_sclk_v;
            sle_prev_q  <= w_sle_v;
        end
    end

    logic w_sclk_fall;
    logic w_sle_rise;
    logic w_sle_fall;
    assign w_sclk_fall = sclk_prev_q & ~w_sclk_v;
    assign w_sle_rise  = ~sle_prev_q & w_sle_v;
    assign w_sle_fall  = sle_prev_q & ~w_sle_v;

    // ------------------------------------------------------------------
    // Frame state machine and datapath
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [31:0] rx_sr_q;
    logic [30:0] tx_sr_q;     // bit 31 of the snapshot goes straight to sdo
    logic [31:0] snap_q;
    logic [6:0]  bit_cnt_q;
    logic        rise_pend_q; // sle rise that arrived during COMMIT
    logic [31:0] port_out_q;
    logic        sdo_q;
    logic        int_q;
    logic        done_q;
    logic        err_q;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state_q     <= ST_IDLE;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            snap_q      <= '0;
            bit_cnt_q   <= '0;
            rise_pend_q <= 1'b0;
            port_out_q  <= OUT_RESET;
            sdo_q       <= 1'b0;
            int_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_sle_rise || rise_pend_q) begin
                        state_q     <= ST_SHIFT;
                        tx_sr_q     <= port_in[30:0];
                        snap_q      <= port_in;
                        bit_cnt_q   <= '0;
                        sdo_q       <= port_in[31];
                        int_q       <= 1'b0;
                        rise_pend_q <= 1'b0;
                    end else if (port_in != snap_q) begin
                        int_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // A fall coinciding with the sle fall is still counted
                    if (w_sclk_fall) begin
                        rx_sr_q <= {rx_sr_q[30:0], w_sdi_s};
                        tx_sr_q <= {tx_sr_q[29:0], 1'b0};
                        sdo_q   <= tx_sr_q[30];
                        if (bit_cnt_q != C_CNT_MAX) begin
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                        end
                    end
                    if (w_sle_fall) begin
                        state_q <= ST_COMMIT;
                    end
                    if (port_in != snap_q) begin
                        int_q <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (bit_cnt_q >= C_MIN_BITS) begin
                        port_out_q <= rx_sr_q;
                        done_q     <= 1'b1;
                        err_q      <= 1'b0;
                    end else begin
                        err_q <= 1'b1;
                    end
                    if (w_sle_rise) begin
                        rise_pend_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign port_out   = port_out_q;
    assign epl_sdo    = sdo_q;
    assign epl_int    = int_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sio32_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sio32_slave
//  Purpose  : Directed self-checking bench for sio32_slave. A behavioural
//             master drives framed serial traffic; expected values are
//             hand-computed constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sio32_slave;

    localparam int          SYNC_STAGES = 2;
    localparam logic [31:0] OUT_RESET   = 32'h0000_0000;
    localparam int          MIN_BITS    = 32;
`ifdef SIO32_SLAVE_GLITCH_FILTER_EN
    localparam int LAT = SYNC_STAGES + 4;
`else
    localparam int LAT = SYNC_STAGES + 2;
`endif

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        sdi;
    logic        sle;
    logic        sdo;
    logic        irq;
    logic [31:0] pin;
    logic [31:0] pout;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fails  = 0;
    int done_cnt = 0;

    sio32_slave #(
        .SYNC_STAGES (SYNC_STAGES),
        .OUT_RESET   (OUT_RESET),
        .MIN_BITS    (MIN_BITS)
    ) u_dut (
        .csi_MCLK_clk   (clk),
        .rsi_MRST_reset (rst),
        .epl_sclk       (sclk),
        .epl_sdi        (sdi),
        .epl_sle        (sle),
        .epl_sdo        (sdo),
        .epl_int        (irq),
        .port_in        (pin),
        .port_out       (pout),
        .frame_done     (done),
        .frame_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise sle and clock out n bits, data[n-1] first. sle is left high.
    // Returns the first 32 sdo bits the master sampled on sclk rise and
    // a count of sdo changes seen across a rise.
    task automatic send_frame(input logic [127:0] data, input int n,
                              output logic [31:0] got, output int unstable);
        logic pre;
        got      = '0;
        unstable = 0;
        @(negedge clk) sle = 1'b1;
        wait_neg(8);
        for (int i = 0; i < n; i++) begin
            pre = sdo;
            @(negedge clk) sclk = 1'b1;
            if (i < 32) got = {got[30:0], pre};
            wait_neg(2);
            if (sdo !== pre) unstable = unstable + 1;
            wait_neg(1);
            sdi = data[n-1-i];
            wait_neg(5);
            sclk = 1'b0;
            wait_neg(10);
        end
    endtask

    // Drop sle and check the commit lands exactly LAT clocks later.
    task automatic end_frame(input string tag, input logic [31:0] old_out,
                             input logic [31:0] new_out, input logic good);
        int c0;
        c0 = done_cnt;
        @(negedge clk) sle = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1 check({tag, "_pre"}, pout, old_out);
        @(posedge clk);
        #1 check({tag, "_out"}, pout, new_out);
        check({tag, "_done"}, {31'b0, done}, {31'b0, good});
        wait_neg(6);
        check({tag, "_ndone"}, done_cnt - c0, good ? 32'd1 : 32'd0);
        check({tag, "_err"}, {31'b0, err}, {31'b0, ~good});
    endtask

    logic [31:0] got;
    int          unst;

    initial begin
        rst  = 1'b1;
        sclk = 1'b0;
        sdi  = 1'b0;
        sle  = 1'b0;
        pin  = 32'h0;
        wait_neg(4);
        check("rst_out", pout, OUT_RESET);
        check("rst_sdo", {31'b0, sdo}, 32'd0);
        check("rst_int", {31'b0, irq}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        wait_neg(4);

        // 1: basic 32-bit frame
        send_frame({96'h0, 32'hA5A5_0F0F}, 32, got, unst);
        end_frame("t1", OUT_RESET, 32'hA5A5_0F0F, 1'b1);
        check("t1_int", {31'b0, irq}, 32'd0);

        // 2: readback of port_in
        pin = 32'h1234_5678;
        wait_neg(4);
        check("t2_int_pre", {31'b0, irq}, 32'd1);
        send_frame(128'h0, 32, got, unst);
        check("t2_sdo_word", got, 32'h1234_5678);
        check("t2_sdo_stable", unst, 32'd0);
        check("t2_int_clr", {31'b0, irq}, 32'd0);
        end_frame("t2", 32'hA5A5_0F0F, 32'h0000_0000, 1'b1);

        // 3: long frame, last 32 bits win
        pin = 32'h0;
        send_frame({62'h0, 34'h2_AAAA_5555, 32'hDEAD_BEEF}, 66, got, unst);
        end_frame("t3", 32'h0000_0000, 32'hDEAD_BEEF, 1'b1);

        // 5: input change raises int until the next sle rise
        check("t5_int0", {31'b0, irq}, 32'd0);
        @(negedge clk) pin = 32'h0000_0100;
        wait_neg(3);
        check("t5_int1", {31'b0, irq}, 32'd1);
        wait_neg(20);
        check("t5_int_hold", {31'b0, irq}, 32'd1);

        // 4: short frames keep port_out and set frame_err
        send_frame({96'h0, 32'h0000_03FF}, 10, got, unst);
        check("t5_int_clr", {31'b0, irq}, 32'd0);
        end_frame("t4a", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        send_frame({96'h0, 32'h7FFF_FFFF}, 31, got, unst);
        end_frame("t4b", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        send_frame({96'h0, 32'h0000_0001}, 32, got, unst);
        end_frame("t4c", 32'hDEAD_BEEF, 32'h0000_0001, 1'b1);

        // 6: reset mid-frame
        pin = 32'h8000_0000;
        send_frame({96'h0, 32'h0000_FFFF}, 16, got, unst);
        @(negedge clk);
        rst = 1'b1;
        sle = 1'b0;
        #1;
        check("t6_rst_out", pout, OUT_RESET);
        check("t6_rst_sdo", {31'b0, sdo}, 32'd0);
        wait_neg(3);
        rst = 1'b0;
        pin = 32'h0;
        wait_neg(4);
        send_frame({96'h0, 32'hCAFE_F00D}, 32, got, unst);
        end_frame("t6", OUT_RESET, 32'hCAFE_F00D, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sio32_slave.md
Name: sio32_slave

Overview:
- Serial I/O expander on the EPL side of the SIO32 link; the serial peer of the SIO32 Qsys master.
- Oversamples EPL_SCLK/EPL_SDI/EPL_SLE in its own system clock domain.
- Deserialises 32 output bits onto `port_out` and serialises a 32-bit snapshot of `port_in` back on EPL_SDO.
- Raises EPL_INT when `port_in` changes after the last snapshot sent.

Parameters:
- `SYNC_STAGES`, 2, synchroniser depth on sclk/sdi/sle inputs (min 2).
- `OUT_RESET`, 32'h0000_0000, reset value of `port_out`.
- `MIN_BITS`, 32, minimum falling SCLK edges in a frame for the frame to commit.

Ports:
- `csi_MCLK_clk`  in  1  system clock; frequency ≥ 8× EPL_SCLK.
- `rsi_MRST_reset`  in  1  asynchronous active-high reset.
- `epl_sclk`  in  1  serial clock from master.
- `epl_sdi`  in  1  serial data from master; master changes it after SCLK rise.
- `epl_sle`  in  1  frame enable from master; high = shifting.
- `epl_sdo`  out  1  serial data to master; master samples it on SCLK rise.
- `epl_int`  out  1  input-change interrupt, level.
- `port_in`  in  32  parallel inputs to report.
- `port_out`  out  32  parallel outputs received.
- `frame_done`  out  1  one-cycle pulse when `port_out` commits.
- `frame_err`  out  1  sticky: a frame ended with fewer than `MIN_BITS` edges; cleared by the next good frame.

Behaviour:
- Clock and reset:
  - One clock, `csi_MCLK_clk`.
  - Reset `rsi_MRST_reset` is asynchronous, active-high; applies to all flops, including synchronisers.
- Reset values:
  - `port_out` = `OUT_RESET`.
  - `epl_sdo` = 0, `epl_int` = 0, `frame_done` = 0, `frame_err` = 0.
  - Internal registers: shift registers = 0, bit_cnt = 0, snap = 0, state = IDLE.
- Synchronisation: `epl_sclk`, `epl_sdi` and `epl_sle` each pass through `SYNC_STAGES` flops. One extra flop on sclk and sle provides edge detection (`rise`/`fall` pulses, one cycle wide).
- States:
  - IDLE → SHIFT on sle rise.
  - SHIFT → COMMIT on sle fall.
  - COMMIT → IDLE after 1 cycle.
- sle rise (entering SHIFT):
  - tx_sr <= `port_in`; snap <= `port_in`; bit_cnt <= 0.
  - `epl_sdo` <= `port_in[31]`.
  - `epl_int` <= 0.
- SHIFT, on each sclk fall:
  - rx_sr <= {rx_sr[30:0], sdi_sync}.
  - tx_sr <= {tx_sr[30:0], 1'b0}; `epl_sdo` <= tx_sr[30].
  - bit_cnt increments, saturating at 127 (7-bit counter).
  - rx_sr is rolling, so `port_out` always gets the LAST 32 bits shifted in.
  - sclk rise in SHIFT: no action.
- COMMIT:
  - If bit_cnt ≥ `MIN_BITS`: `port_out` <= rx_sr, `frame_done` = 1 for this cycle, `frame_err` <= 0.
  - Otherwise: `port_out` holds, `frame_err` <= 1.
- Latency: `port_out` and `frame_done` update `SYNC_STAGES`+2 clocks after the sle falling pin edge.
- Simultaneous events:
  - sclk fall in the same cycle as sle fall: the edge is counted and shifted before COMMIT evaluates.
  - sclk edges in IDLE are ignored.
- `epl_int`:
  - Set when state = IDLE or SHIFT and `port_in` ≠ snap.
  - Cleared only at the next sle rise.
  - Before the first frame after reset, snap = 0, so any nonzero `port_in` asserts int.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is lost and `port_out` = `OUT_RESET`.
- Back-to-back frames: sle may rise in the cycle after COMMIT. An sle rise seen during COMMIT is held and acted on in IDLE on the next cycle.

Optional Feature:
- Macro: `SIO32_SLAVE_GLITCH_FILTER_EN`.
- When defined:
  - Synchronised sclk and sle pass a 3-sample majority filter before edge detection, rejecting single-cycle glitches.
  - Adds 2 cycles to every latency figure above.
- When undefined: edges are detected directly on the synchroniser output.

Test Plan:
1. Reset with `port_in` = 0, then frame with 32 falls, SDI = 32'hA5A5_0F0F MSB first → `port_out` = 32'hA5A5_0F0F, one `frame_done` pulse, `frame_err` = 0.
2. `port_in` = 32'h1234_5678 before sle rise, master samples SDO on 32 rises → master receives 32'h1234_5678 MSB first; `epl_sdo` is stable at every sclk rise.
3. Master-style frame of 66 falls; the last 32 SDI bits are 32'hDEAD_BEEF → `port_out` = 32'hDEAD_BEEF.
4. Frame with only 10 falls → `port_out` unchanged, `frame_err` = 1, no `frame_done`. A following good frame with 32'h0000_0001 → `port_out` = 32'h0000_0001, `frame_err` = 0.
5. After a frame with `port_in` = 32'h0, drive `port_in` = 32'h0000_0100 → `epl_int` = 1 until the next sle rise, then `epl_int` = 0.
6. Assert reset after 16 falls of a frame → `port_out` = `OUT_RESET`, `epl_sdo` = 0; a subsequent full frame with 32'hCAFE_F00D commits normally.
